icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter DEPTH, default 64: number of cache lines, power of two, at least 2.
REQ-002 SHALL have parameter LINE_WORDS, default 4: 32-bit words per line, power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port cpu_req, input, 1 bit: fetch request.
REQ-007 SHALL have port cpu_addr, input, ADDR_W bits: fetch byte address; bits [1:0] ignored.
REQ-008 SHALL have port cpu_ready, output, 1 bit: a request is accepted this cycle if cpu_req is also high.
REQ-009 SHALL have port cpu_valid, output, 1 bit: one-cycle pulse; cpu_ins is valid.
REQ-010 SHALL have port cpu_ins, output, 32 bits: fetched instruction.
REQ-011 SHALL have port flush, input, 1 bit: invalidate all lines.
REQ-012 SHALL have port mem_req, output, 1 bit: refill beat request.
REQ-013 SHALL have port mem_addr, output, ADDR_W bits: word-aligned address of the current beat.
REQ-014 SHALL have port mem_ack, input, 1 bit: mem_rdata is valid and the beat completes.
REQ-015 SHALL have port mem_rdata, input, 32 bits: refill word.

Function
REQ-016 SHALL decompose the address as: offset = log2(LINE_WORDS) bits above bit 1, index = log2(DEPTH) bits above offset, tag = remaining upper bits.
REQ-017 SHALL store, per line, a valid bit, a tag, and LINE_WORDS data words (direct-mapped).
REQ-018 SHALL implement FSM states IDLE, LOOKUP, REFILL and RESPOND.
REQ-019 SHALL assert cpu_ready only in IDLE with flush low; an accepted request registers the address and moves to LOOKUP.
REQ-020 SHALL, in LOOKUP on a hit (valid set and tag equal), pulse cpu_valid with the addressed word and return to IDLE; hit latency is 2 cycles from acceptance to cpu_valid.
REQ-021 SHALL, in LOOKUP on a miss, enter REFILL with the beat counter at 0.
REQ-022 SHALL, in REFILL, hold mem_req high with mem_addr = {tag, index, counter, 2'b00}; each mem_ack writes mem_rdata to word[counter] and increments the counter.
REQ-023 SHALL tolerate any number of mem_ack-low cycles, holding mem_addr stable while mem_ack is low.
REQ-024 SHALL, on the last beat (counter = LINE_WORDS-1 with mem_ack), write the tag, set the valid bit, drop mem_req on the next cycle, and enter RESPOND.
REQ-025 SHALL, in RESPOND, pulse cpu_valid with the requested word and return to IDLE.
REQ-026 SHALL keep the line's valid bit clear for the whole refill, so a partial line never hits.
REQ-027 SHALL, in IDLE with flush high, clear all valid bits in that cycle; a simultaneous cpu_req is not accepted.
REQ-028 SHALL, on flush outside IDLE, latch it as pending; it applies on the first IDLE cycle, including the valid bit of the line just refilled.
REQ-029 SHALL hold cpu_ins at its last value when cpu_valid is low.

Reset
REQ-030 SHALL, on rst_n low at any time, including mid-refill: enter IDLE; clear all valid bits, the beat counter and any pending flush; drive mem_req=0, cpu_valid=0, cpu_ready=0, cpu_ins=0 and mem_addr=0.
REQ-031 SHALL raise cpu_ready on the first clock edge after rst_n is released.

Verification
REQ-032 SHALL be verified with DEPTH=16, LINE_WORDS=4 for all of the following scenarios.
REQ-033 Cold miss: request 0x104, memory returns 0xA0..0xA3 -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C, then cpu_valid with cpu_ins=0xA1.
REQ-034 Hit: then request 0x108 -> cpu_valid 2 cycles after acceptance with cpu_ins=0xA2, and mem_req stays low.
REQ-035 Conflict: then request 0x500 (same index, new tag), refill with 0xB0..0xB3 -> cpu_ins=0xB0; re-request 0x100 -> misses and refills.
REQ-036 Stalls: mem_ack low for 3 cycles between beats -> mem_addr held stable and correct data assembled.
REQ-037 Flush: flush in IDLE together with cpu_req -> request not accepted; a following 0x100 request misses. Flush during a refill -> that line misses afterwards.
REQ-038 Reset mid-refill: rst_n low after 2 acks -> mem_req=0 and state IDLE; re-request of the same address misses.

Source files
------------

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache. The line is refilled one word
// per memory beat, and a request is answered from a registered output stage.
//
// state   | meaning
// IDLE    | accept a fetch; apply a direct or pending flush
// LOOKUP  | compare the tag of the registered address
// REFILL  | fetch the line word by word; the line stays invalid throughout
// RESPOND | return the requested word of the line just filled
module icache_dm #(
  parameter int DEPTH      = 64,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic [31:0]       cpu_ins,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - 2;
  localparam int TAG_W = WA_W - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    REFILL  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WA_W-1:0]  addr_q, addr_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             flush_pend_q, flush_pend_d;
  logic             ready_en_q, ready_en_d;
  logic             cpu_valid_q, cpu_valid_d;
  logic [31:0]      cpu_ins_q, cpu_ins_d;

  // Tags and data are plain storage; validity is tracked in valid_q.
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [31:0]      data_mem [DEPTH*LINE_WORDS];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             hit;
  logic [31:0]      rd_word;
  logic             data_we;
  logic             tag_we;
  logic             unused_byte_bits;

  // Fetches are word-granular, so the byte-select bits carry no information.
  assign unused_byte_bits = ^cpu_addr[1:0];

  assign req_tag = addr_q[WA_W-1 -: TAG_W];
  assign req_idx = addr_q[OFF_W +: IDX_W];
  assign req_off = addr_q[OFF_W-1:0];
  assign hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign rd_word = data_mem[{req_idx, req_off}];

  // ready_en_q keeps cpu_ready low until the first edge after reset release.
  assign cpu_ready = ready_en_q && (state_q == IDLE) && !flush;
  assign mem_req   = (state_q == REFILL);
  assign mem_addr  = mem_req ? {addr_q[WA_W-1:OFF_W], cnt_q, 2'b00} : '0;
  assign cpu_valid = cpu_valid_q;
  assign cpu_ins   = cpu_ins_q;

  // Next-state, refill sequencing, flush handling and response capture.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    ready_en_d   = 1'b1;
    cpu_valid_d  = 1'b0;
    cpu_ins_d    = cpu_ins_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;

    // A flush seen while busy is deferred until the controller is back in IDLE.
    if ((state_q != IDLE) && flush) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (flush || flush_pend_q) begin
          valid_d      = '0;
          flush_pend_d = 1'b0;
        end
        if (cpu_ready && cpu_req) begin
          addr_d  = cpu_addr[ADDR_W-1:2];
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (hit) begin
          cpu_valid_d = 1'b1;
          cpu_ins_d   = rd_word;
          state_d     = IDLE;
        end else begin
          // The victim line is invalidated now, so a partial refill never hits.
          valid_d[req_idx] = 1'b0;
          cnt_d            = '0;
          state_d          = REFILL;
        end
      end

      REFILL: begin
        if (mem_ack) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_BEAT) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            state_d          = RESPOND;
          end
        end
      end

      RESPOND: begin
        cpu_valid_d = 1'b1;
        cpu_ins_d   = rd_word;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers; reset returns the cache to an empty, idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      ready_en_q   <= 1'b0;
      cpu_valid_q  <= 1'b0;
      cpu_ins_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      ready_en_q   <= ready_en_d;
      cpu_valid_q  <= cpu_valid_d;
      cpu_ins_q    <= cpu_ins_d;
    end
  end

  // Line storage writes: one data word per refill beat, and the tag on the last beat.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{req_idx, cnt_q}] <= mem_rdata;
    end
    if (tag_we) begin
      tag_mem[req_idx] <= req_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed and random fetch sequences against a line-level
// model of a direct-mapped cache (valid/tag/data arrays indexed by address).
module tb_icache_dm;

  localparam int DEPTH = 16;
  localparam int LW    = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_ready;
  logic          cpu_valid;
  logic [31:0]   cpu_ins;
  logic          flush = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  logic [31:0] m_data  [DEPTH][LW];

  icache_dm #(.DEPTH(DEPTH), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_valid (cpu_valid),
    .cpu_ins   (cpu_ins),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch: the bench acts as memory (word k of a refill = base + k).
  // stall < 0 selects random ack gaps; flush_beat/rst_acks < 0 disable those events.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] base, input int stall,
                          input int flush_beat, input int rst_acks);
    int          k;
    int          beats;
    int          stall_left;
    int          idx;
    int unsigned tg;
    int          off;
    bit          exp_hit;
    bit          got;
    bit          pend;
    logic [31:0] exp_ins;

    idx = int'((addr >> 4) % DEPTH);
    off = int'((addr >> 2) % LW);
    tg  = addr >> 8;

    k = 0;
    while (!cpu_ready && k < 20) begin
      tick;
      k++;
    end
    chk("ready_before_req", cpu_ready, 1);

    exp_hit  = m_valid[idx] && (m_tag[idx] == tg);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    tick;
    cpu_req  = 1'b0;
    cpu_addr = $urandom;
    if (!exp_hit) m_valid[idx] = 1'b0;

    beats = 0; stall_left = 0; got = 1'b0; pend = 1'b0; k = 0;
    while (!got && k < 300) begin
      mem_ack = 1'b0;
      flush   = 1'b0;
      if (cpu_valid) begin
        got = 1'b1;
      end else begin
        if (mem_req) begin
          chk("mem_addr", mem_addr, (addr & ~32'hF) | 32'(beats << 2));
          if (rst_acks >= 0 && beats == rst_acks) begin
            rst_n = 1'b0;
            #1;
            chk("rst_mem_req", mem_req, 0);
            chk("rst_cpu_valid", cpu_valid, 0);
            chk("rst_cpu_ready", cpu_ready, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_cpu_ins", cpu_ins, 0);
            clear_model();
            tick;
            tick;
            rst_n = 1'b1;
            #1;
            chk("ready_before_edge", cpu_ready, 0);
            tick;
            chk("ready_after_release", cpu_ready, 1);
            return;
          end
          if (flush_beat >= 0 && beats == flush_beat && !pend) begin
            flush = 1'b1;
            pend  = 1'b1;
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            mem_ack   = 1'b1;
            mem_rdata = base + 32'(beats);
            if (beats < LW) m_data[idx][beats] = base + 32'(beats);
            beats++;
            stall_left = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
          end
        end
        tick;
        k++;
      end
    end
    mem_ack = 1'b0;
    flush   = 1'b0;

    chk("fetch_done", got, 1);
    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    exp_ins = m_data[idx][off];
    if (pend) clear_model();

    if (got) begin
      chk("cpu_ins", cpu_ins, exp_ins);
      chk("refill_beats", beats, exp_hit ? 0 : LW);
      if (exp_hit) chk("hit_latency", k + 1, 2);
      chk("mem_req_at_valid", mem_req, 0);
      tick;
      chk("valid_pulse", cpu_valid, 0);
      chk("ins_hold", cpu_ins, exp_ins);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          fb;

    clear_model();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cpu_ready", cpu_ready, 0);
    chk("reset_cpu_valid", cpu_valid, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_cpu_ins", cpu_ins, 0);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", cpu_ready, 0);
    tick;
    chk("ready_first_edge", cpu_ready, 1);

    // cold miss, hit, conflict eviction and re-fetch of the evicted line
    do_fetch(32'h104, 32'hA0, 0, -1, -1);
    chk("cold_ins", cpu_ins, 32'hA1);
    do_fetch(32'h108, 32'h0, 0, -1, -1);
    chk("hit_ins", cpu_ins, 32'hA2);
    do_fetch(32'h500, 32'hB0, 0, -1, -1);
    chk("conflict_ins", cpu_ins, 32'hB0);
    do_fetch(32'h100, 32'hC0, 0, -1, -1);
    chk("refetch_ins", cpu_ins, 32'hC0);

    // three-cycle ack gaps between beats
    do_fetch(32'h20C, 32'hD0, 3, -1, -1);
    chk("stall_ins", cpu_ins, 32'hD3);

    // flush in IDLE blocks a simultaneous request and empties the cache
    flush    = 1'b1;
    cpu_req  = 1'b1;
    cpu_addr = 32'h100;
    #1;
    chk("flush_ready_low", cpu_ready, 0);
    tick;
    flush   = 1'b0;
    cpu_req = 1'b0;
    #1;
    chk("flush_req_not_taken", cpu_ready, 1);
    clear_model();
    do_fetch(32'h100, 32'hE0, 0, -1, -1);

    // flush during a refill invalidates that line afterwards
    do_fetch(32'h304, 32'hF0, 1, 2, -1);
    do_fetch(32'h304, 32'h70, 0, -1, -1);
    chk("post_flush_refill_ins", cpu_ins, 32'h71);

    // reset after two acks, then the same address must refill
    do_fetch(32'h408, 32'h80, 0, -1, 2);
    do_fetch(32'h408, 32'h90, 0, -1, -1);
    chk("post_reset_refill_ins", cpu_ins, 32'h92);

    // random traffic over a small tag range so hits and conflicts both occur
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, DEPTH - 1)) << 4) |
          (32'($urandom_range(0, LW - 1)) << 2) | 32'($urandom_range(0, 3));
      fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      do_fetch(a, $urandom, -1, fb, -1);
      if ($urandom_range(0, 9) == 0) begin
        flush = 1'b1;
        tick;
        flush = 1'b0;
        clear_model();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
